// File: rtl/conv_mac_controller_pkg.sv
// Shared state encoding and window-count helper for the convolution MAC controller.
package conv_ctrl_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_ISSUE  = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN1 = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN2 = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_OUT    = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_DONE   = 3'd5;

  // Number of stride-spaced windows that fit in the IF-map for one filter.
  function automatic int unsigned num_windows(input int unsigned if_size,
                                              input int unsigned filter_size,
                                              input int unsigned stride);
    return (if_size - filter_size) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac_controller_mod_counter.sv
// Modulo counter with synchronous clear/increment; exposes its next value and terminal count.
module mod_counter
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] next_c,
  output logic             tc_c
);

  logic [WIDTH-1:0] count;

  // Terminal count flags the last value before wrap.
  always_comb begin
    tc_c = (count == WIDTH'(MODULUS - 1));
  end

  // Next value: clear wins, otherwise wrap to zero after the terminal value.
  always_comb begin
    next_c = count;
    if (clr) begin
      next_c = '0;
    end else if (inc) begin
      next_c = tc_c ? '0 : count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= next_c;
    end
  end

endmodule

// File: rtl/conv_mac_controller.sv
// Sequencer for the 1-D convolution MAC: issues SRAM reads per tap, pipelines the
// product/accumulate strobes and hands finished window sums to the psum writer.
module conv_mac_controller
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned IF_SIZE     = 16,
  parameter int unsigned FILTER_SIZE = 4,
  parameter int unsigned STRIDE      = 2,
  parameter int unsigned NUM_FILTERS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  if_ren,
  output logic [ADDR_WIDTH-1:0] if_raddr,
  output logic                  filt_ren,
  output logic [ADDR_WIDTH-1:0] filt_raddr,
  output logic                  prod_ld,
  output logic                  acc_clr,
  output logic                  acc_ld,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic [ADDR_WIDTH-1:0] psum_filter,
  output logic [ADDR_WIDTH-1:0] psum_window,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NW       = num_windows(IF_SIZE, FILTER_SIZE, STRIDE);
  localparam int unsigned ADDR_MAX = (32'd1 << ADDR_WIDTH) - 32'd1;

  // Reject geometries that leave a ragged tail or overflow the address/index ports.
  if (STRIDE == 0 || FILTER_SIZE == 0 || FILTER_SIZE > IF_SIZE) begin : g_bad_geometry
    $error("conv_mac_controller: invalid STRIDE/FILTER_SIZE/IF_SIZE");
  end
  if ((IF_SIZE - FILTER_SIZE) % STRIDE != 0) begin : g_bad_stride
    $error("conv_mac_controller: (IF_SIZE - FILTER_SIZE) not a multiple of STRIDE");
  end
  if (IF_SIZE - 1 > ADDR_MAX) begin : g_bad_if_addr
    $error("conv_mac_controller: IF-map address exceeds ADDR_WIDTH");
  end
  if (NUM_FILTERS * FILTER_SIZE - 1 > ADDR_MAX) begin : g_bad_filt_addr
    $error("conv_mac_controller: filter address exceeds ADDR_WIDTH");
  end
  if (NW - 1 > ADDR_MAX || NUM_FILTERS - 1 > ADDR_MAX) begin : g_bad_index
    $error("conv_mac_controller: window/filter index exceeds ADDR_WIDTH");
  end

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] state_nxt;

  logic                  accept;
  logic                  k_tc;
  logic                  w_tc;
  logic                  f_tc;
  logic [ADDR_WIDTH-1:0] k_next;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [ADDR_WIDTH-1:0] f_next;

  logic                  if_ren_n;
  logic [ADDR_WIDTH-1:0] if_raddr_n;
  logic [ADDR_WIDTH-1:0] filt_raddr_n;
  logic                  acc_clr_n;
  logic                  psum_valid_n;
  logic [ADDR_WIDTH-1:0] psum_filter_n;
  logic [ADDR_WIDTH-1:0] psum_window_n;
  logic                  busy_n;
  logic                  done_n;

  assign accept = (state == ST_OUT) && psum_ready;

  // Tap counter: advances once per issued read.
  mod_counter #(.MODULUS(FILTER_SIZE), .WIDTH(ADDR_WIDTH)) u_k_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .inc    (state == ST_ISSUE),
    .next_c (k_next),
    .tc_c   (k_tc)
  );

  // Window counter: advances when a sum is accepted.
  mod_counter #(.MODULUS(NW), .WIDTH(ADDR_WIDTH)) u_w_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .inc    (accept),
    .next_c (w_next),
    .tc_c   (w_tc)
  );

  // Filter counter: advances when the last window of a filter is accepted.
  mod_counter #(.MODULUS(NUM_FILTERS), .WIDTH(ADDR_WIDTH)) u_f_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .inc    (accept && w_tc),
    .next_c (f_next),
    .tc_c   (f_tc)
  );

  // Next state and next-cycle output values, derived from next state and counters.
  always_comb begin
    state_nxt     = state;
    if_ren_n      = 1'b0;
    if_raddr_n    = '0;
    filt_raddr_n  = '0;
    acc_clr_n     = 1'b0;
    psum_valid_n  = 1'b0;
    psum_filter_n = '0;
    psum_window_n = '0;
    busy_n        = 1'b0;
    done_n        = 1'b0;

    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (k_tc) state_nxt = ST_DRAIN1;
      ST_DRAIN1: state_nxt = ST_DRAIN2;
      ST_DRAIN2: state_nxt = ST_OUT;
      ST_OUT:    if (psum_ready) state_nxt = (w_tc && f_tc) ? ST_DONE : ST_ISSUE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_ISSUE) begin
      if_ren_n     = 1'b1;
      if_raddr_n   = ADDR_WIDTH'(32'(w_next) * STRIDE + 32'(k_next));
      filt_raddr_n = ADDR_WIDTH'(32'(f_next) * FILTER_SIZE + 32'(k_next));
      acc_clr_n    = (k_next == '0);
    end
    if (state_nxt == ST_OUT) begin
      psum_valid_n  = 1'b1;
      psum_filter_n = f_next;
      psum_window_n = w_next;
    end
    busy_n = (state_nxt != ST_IDLE);
    done_n = (state_nxt == ST_DONE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs; prod_ld/acc_ld trail the read strobe by one and two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ren      <= 1'b0;
      filt_ren    <= 1'b0;
      if_raddr    <= '0;
      filt_raddr  <= '0;
      acc_clr     <= 1'b0;
      prod_ld     <= 1'b0;
      acc_ld      <= 1'b0;
      psum_valid  <= 1'b0;
      psum_filter <= '0;
      psum_window <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if_ren      <= if_ren_n;
      filt_ren    <= if_ren_n;
      if_raddr    <= if_raddr_n;
      filt_raddr  <= filt_raddr_n;
      acc_clr     <= acc_clr_n;
      prod_ld     <= if_ren;
      acc_ld      <= prod_ld;
      psum_valid  <= psum_valid_n;
      psum_filter <= psum_filter_n;
      psum_window <= psum_window_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_conv_mac_controller.sv
// Bench for conv_mac_controller: default (stride 2) and stride-4 instances, a
// behavioural SRAM/multiplier/accumulator datapath and loop-nest reference model.
module tb_conv_mac_controller;

  localparam int unsigned AW  = 4;
  localparam int unsigned IFS = 16;
  localparam int unsigned FS  = 4;
  localparam int unsigned NF  = 2;

  typedef struct {
    int ia;
    int fa;
    int k;
  } rd_t;

  typedef struct {
    int     f;
    int     w;
    longint sum;
    int     stall;
  } ps_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic psum_ready = 1'b0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int psum_cnt = 0;
  int done_off = -1;

  rd_t rq[$];
  ps_t sq[$];

  logic [7:0]  ifmem   [16];
  logic [7:0]  filtmem [16];
  logic [7:0]  if_q;
  logic [7:0]  filt_q;
  logic [15:0] prod;
  logic [31:0] acc;

  // Instance A (stride 2) and instance B (stride 4) outputs.
  logic a_if_ren, a_filt_ren, a_prod_ld, a_acc_clr, a_acc_ld, a_psum_valid, a_busy, a_done;
  logic [AW-1:0] a_if_raddr, a_filt_raddr, a_psum_filter, a_psum_window;
  logic b_if_ren, b_filt_ren, b_prod_ld, b_acc_clr, b_acc_ld, b_psum_valid, b_busy, b_done;
  logic [AW-1:0] b_if_raddr, b_filt_raddr, b_psum_filter, b_psum_window;

  logic m_if_ren, m_filt_ren, m_prod_ld, m_acc_clr, m_acc_ld, m_psum_valid, m_busy, m_done;
  logic [AW-1:0] m_if_raddr, m_filt_raddr, m_psum_filter, m_psum_window;
  logic [23:0] a_all;

  conv_mac_controller #(.ADDR_WIDTH(AW), .IF_SIZE(IFS), .FILTER_SIZE(FS), .STRIDE(2), .NUM_FILTERS(NF)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .if_ren(a_if_ren), .if_raddr(a_if_raddr), .filt_ren(a_filt_ren), .filt_raddr(a_filt_raddr),
    .prod_ld(a_prod_ld), .acc_clr(a_acc_clr), .acc_ld(a_acc_ld),
    .psum_valid(a_psum_valid), .psum_ready(psum_ready),
    .psum_filter(a_psum_filter), .psum_window(a_psum_window),
    .busy(a_busy), .done(a_done)
  );

  conv_mac_controller #(.ADDR_WIDTH(AW), .IF_SIZE(IFS), .FILTER_SIZE(FS), .STRIDE(4), .NUM_FILTERS(NF)) dut_s4 (
    .clk(clk), .rst(rst), .start(start & sel),
    .if_ren(b_if_ren), .if_raddr(b_if_raddr), .filt_ren(b_filt_ren), .filt_raddr(b_filt_raddr),
    .prod_ld(b_prod_ld), .acc_clr(b_acc_clr), .acc_ld(b_acc_ld),
    .psum_valid(b_psum_valid), .psum_ready(psum_ready),
    .psum_filter(b_psum_filter), .psum_window(b_psum_window),
    .busy(b_busy), .done(b_done)
  );

  assign m_if_ren      = sel ? b_if_ren      : a_if_ren;
  assign m_if_raddr    = sel ? b_if_raddr    : a_if_raddr;
  assign m_filt_ren    = sel ? b_filt_ren    : a_filt_ren;
  assign m_filt_raddr  = sel ? b_filt_raddr  : a_filt_raddr;
  assign m_prod_ld     = sel ? b_prod_ld     : a_prod_ld;
  assign m_acc_clr     = sel ? b_acc_clr     : a_acc_clr;
  assign m_acc_ld      = sel ? b_acc_ld      : a_acc_ld;
  assign m_psum_valid  = sel ? b_psum_valid  : a_psum_valid;
  assign m_psum_filter = sel ? b_psum_filter : a_psum_filter;
  assign m_psum_window = sel ? b_psum_window : a_psum_window;
  assign m_busy        = sel ? b_busy        : a_busy;
  assign m_done        = sel ? b_done        : a_done;

  assign a_all = {a_if_ren, a_if_raddr, a_filt_ren, a_filt_raddr, a_prod_ld, a_acc_clr,
                  a_acc_ld, a_psum_valid, a_psum_filter, a_psum_window, a_busy, a_done};

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: 1-cycle SRAM reads, product register, accumulator.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if_q   <= '0;
      filt_q <= '0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      if (m_if_ren)   if_q   <= ifmem[m_if_raddr];
      if (m_filt_ren) filt_q <= filtmem[m_filt_raddr];
      if (m_prod_ld)  prod   <= 16'(if_q) * 16'(filt_q);
      if (m_acc_clr)     acc <= '0;
      else if (m_acc_ld) acc <= acc + 32'(prod);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - start_cyc);
    end
  endtask

  // Monitor: checks reads, pipeline strobes and sums; drives psum_ready with planned stalls.
  initial begin
    logic ren_d1;
    logic ren_d2;
    rd_t  e;
    ren_d1 = 1'b0;
    ren_d2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ren_d1 = 1'b0;
        ren_d2 = 1'b0;
      end else begin
        if (m_busy) busy_cnt++;
        if (m_done) begin
          done_cnt++;
          done_off = cyc - start_cyc;
        end
        check("prod_ld", m_prod_ld, ren_d1);
        check("acc_ld", m_acc_ld, ren_d2);
        check("filt_ren", m_filt_ren, m_if_ren);
        ren_d2 = ren_d1;
        ren_d1 = m_if_ren;
        if (m_if_ren) begin
          check("read_pending", longint'(rq.size() > 0), 1);
          if (rq.size() > 0) begin
            e = rq.pop_front();
            check("if_raddr", m_if_raddr, e.ia);
            check("filt_raddr", m_filt_raddr, e.fa);
            check("acc_clr", m_acc_clr, longint'(e.k == 0));
          end
        end else begin
          check("acc_clr_no_read", m_acc_clr, 0);
        end
        if (m_psum_valid) begin
          check("read_in_out", m_if_ren, 0);
          check("psum_pending", longint'(sq.size() > 0), 1);
          if (sq.size() > 0) begin
            check("psum_filter", m_psum_filter, sq[0].f);
            check("psum_window", m_psum_window, sq[0].w);
            check("psum_sum", acc, sq[0].sum);
            if (sq[0].stall > 0) begin
              psum_ready = 1'b0;
              sq[0].stall = sq[0].stall - 1;
            end else begin
              psum_ready = 1'b1;
              void'(sq.pop_front());
              psum_cnt++;
            end
          end
        end else begin
          psum_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Build the expected loop nest for one pass and pulse start; returns expected done offset.
  task automatic begin_pass(input int s, input int nw, input int mode, output int exp_off);
    int tot;
    ps_t p;
    tot = 0;
    rq.delete();
    sq.delete();
    for (int f = 0; f < int'(NF); f++) begin
      for (int w = 0; w < nw; w++) begin
        p.f = f;
        p.w = w;
        p.sum = 0;
        for (int k = 0; k < int'(FS); k++) begin
          rq.push_back('{w * s + k, f * int'(FS) + k, k});
          p.sum += longint'(ifmem[w * s + k]) * longint'(filtmem[f * int'(FS) + k]);
        end
        if (mode == 1)      p.stall = (f == 0 && w == 0) ? 5 : 0;
        else if (mode == 2) p.stall = int'($urandom_range(0, 3));
        else                p.stall = 0;
        tot += p.stall;
        sq.push_back(p);
      end
    end
    exp_off = 1 + int'(NF) * nw * (int'(FS) + 3) + tot;
    busy_cnt = 0;
    done_cnt = 0;
    psum_cnt = 0;
    done_off = -1;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, optionally poking start at cycle 20 and in the done cycle.
  task automatic finish_pass(input int exp_off, input int nw, input bit poke);
    int guard;
    guard = 0;
    while (done_off < 0 && guard < 3000) begin
      @(negedge clk);
      start = poke && (m_done || (cyc == start_cyc + 20));
      guard++;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_cycle", done_off, exp_off);
    repeat (6) @(negedge clk);
    check("psum_count", psum_cnt, int'(NF) * nw);
    check("busy_cycles", busy_cnt, exp_off);
    check("done_pulses", done_cnt, 1);
    check("reads_left", rq.size(), 0);
    check("idle_after", m_busy, 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) begin
      ifmem[i]   = 8'($urandom_range(0, 255));
      filtmem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    int e;
    for (int i = 0; i < 16; i++) begin
      ifmem[i]   = 8'(i + 1);
      filtmem[i] = (i < 4) ? 8'd1 : 8'($urandom_range(0, 255));
    end
    repeat (3) @(negedge clk);
    check("reset_outputs_a", a_all, 0);
    check("reset_busy_b", b_busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp IF-map with unit filter 0; stray start pulses at cycle 20 and in DONE.
    begin_pass(2, 7, 0, e);
    finish_pass(e, 7, 1'b1);

    // Five-cycle stall on the first sum.
    randomize_mem();
    begin_pass(2, 7, 1, e);
    finish_pass(e, 7, 1'b0);

    // Random data with random stalls.
    randomize_mem();
    begin_pass(2, 7, 2, e);
    finish_pass(e, 7, 1'b0);

    // Reset in the middle of window 3 issue, then a clean restart.
    randomize_mem();
    begin_pass(2, 7, 0, e);
    while (cyc < start_cyc + 23) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async", a_all, 0);
    @(negedge clk);
    check("reset_hold", a_all, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_idle", a_all, 0);
    begin_pass(2, 7, 2, e);
    finish_pass(e, 7, 1'b0);

    // Stride-4 instance: four windows per filter.
    sel = 1'b1;
    randomize_mem();
    begin_pass(4, 4, 0, e);
    finish_pass(e, 4, 1'b0);
    randomize_mem();
    begin_pass(4, 4, 2, e);
    finish_pass(e, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mac_controller.md
# conv_mac_controller

Sequencing FSM for the 1-D convolution MAC datapath: the IF-map SRAM, filter SRAM, product register and accumulator register with adder feedback. For every filter and every stride-spaced window it issues synchronous SRAM reads, drives the product/accumulate load strobes with the correct pipeline offset and hands each finished partial sum to the psum writer over a valid/ready handshake. It replaces hand-driven `ld`/`ren`/`cnt_en` control and is the only master of both scratchpad read ports.

## Interface
- ADDR_WIDTH, 4: width of both SRAM read addresses.
- IF_SIZE, 16: IF-map length in words.
- FILTER_SIZE, 4: taps per filter.
- STRIDE, 2: window advance in words.
- NUM_FILTERS, 2: filters stored back-to-back in the filter SRAM.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a full pass; sampled only in IDLE.
- if_ren  out  1  IF-map SRAM read enable.
- if_raddr  out  ADDR_WIDTH  IF-map read address.
- filt_ren  out  1  filter SRAM read enable.
- filt_raddr  out  ADDR_WIDTH  filter read address.
- prod_ld  out  1  load product register (multiplier output).
- acc_clr  out  1  synchronous clear of accumulator register.
- acc_ld  out  1  load accumulator with adder output.
- psum_valid  out  1  accumulator holds a finished window sum.
- psum_ready  in  1  psum writer accepts it.
- psum_filter  out  ADDR_WIDTH  filter index of current sum.
- psum_window  out  ADDR_WIDTH  window index of current sum.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last sum accepted.

## Operation
- NW = (IF_SIZE - FILTER_SIZE)/STRIDE + 1 windows per filter (default 7); elaboration error if (IF_SIZE - FILTER_SIZE) % STRIDE != 0 or any address exceeds 2^ADDR_WIDTH - 1.
- Loop order: filter f outer (0..NUM_FILTERS-1), window w middle (0..NW-1), tap k inner (0..FILTER_SIZE-1).
- Addresses: if_raddr = w*STRIDE + k; filt_raddr = f*FILTER_SIZE + k; unsigned, no wrap permitted.
- States: IDLE -> (start) ISSUE -> (k = FILTER_SIZE-1) DRAIN1 -> DRAIN2 -> OUT -> (psum_ready) ISSUE next window, or DONE after last window of last filter -> IDLE.
- ISSUE: if_ren = filt_ren = 1, k increments; acc_clr = 1 on k = 0 only.
- prod_ld = if_ren delayed 1 cycle; acc_ld = if_ren delayed 2 cycles (SRAM read latency 1, product register 1).
- OUT: psum_valid = 1, psum_filter/psum_window stable; hold indefinitely while psum_ready = 0; all other strobes 0.
- start in any state but IDLE ignored; start during DONE ignored.
- Reset (any time): state IDLE, k/w/f = 0, all outputs 0, pipeline delay flops 0; an in-flight window is discarded, no psum_valid.

## Timing
- start sampled high at cycle 0 -> first ISSUE at cycle 1.
- Per window with psum_ready high: FILTER_SIZE issue + 2 drain + 1 OUT = FILTER_SIZE + 3 cycles.
- Defaults: windows at cycles 1..7, 8..14, ...; last OUT at cycle 98; done at cycle 99; busy high cycles 1..99.
- psum_ready low for N cycles in OUT adds exactly N cycles; no read issued while stalled.
- Accumulator result valid exactly in the OUT cycle(s).

## Structure
- Package conv_ctrl_pkg: state enum (IDLE, ISSUE, DRAIN1, DRAIN2, OUT, DONE), localparam function for NW.
- One sub-module natural: mod_counter (parameterised modulus, clr/inc/terminal-count) instantiated three times for k, w, f; w/f increment on OUT & psum_ready.

## Test plan
- Defaults, psum_ready tied 1, start at cycle 0 -> 14 psum_valid pulses, first window reads if 0..3/filt 0..3, done at cycle 99.
- IF-map = 1..16, filter0 = {1,1,1,1} -> window 0 sum 10, window 6 sum 58 with model datapath.
- psum_ready low 5 cycles in first OUT -> psum_valid held, indices stable, done at cycle 104.
- start pulsed at cycle 20 and at done cycle -> no effect; second pass only from later start in IDLE.
- rst asserted mid-ISSUE of window 3 -> all outputs 0 same cycle, no psum_valid; restart produces full 14 sums.
- STRIDE = 4, FILTER_SIZE = 4 -> NW = 4; if_raddr bases 0, 4, 8, 12; done at cycle 1 + 2*4*7 = 57.
